// File: rtl/instr_mem.sv
// Per-core instruction memory: word-addressed RAM with a combinational fetch
// port, a synchronous loader write port, and an async clear-to-zero reset.
module instr_mem #(
  parameter int INSTR_WIDTH = 8,
  parameter int PC_WIDTH    = 4,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    raddr,
  output logic [INSTR_WIDTH-1:0] rdata,
  input  logic                   we,
  input  logic [PC_WIDTH-1:0]    waddr,
  input  logic [INSTR_WIDTH-1:0] wdata
);

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
  logic                   w_wr_ok;
  logic                   w_rd_ok;

  // Addresses at or beyond DEPTH are dropped on write and read back as zero.
  assign w_wr_ok = (32'(waddr) < DEPTH);
  assign w_rd_ok = (32'(raddr) < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we && w_wr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = w_rd_ok ? r_mem[raddr] : '0;

endmodule

// File: tb/tb_instr_mem.sv
// Randomized bench for instr_mem: a DEPTH=16 and a DEPTH=12 instance share
// stimulus and are compared against plain-array reference memories.
module tb_instr_mem;
  logic       clk;
  logic       rst_n;
  logic [3:0] raddr;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata16;
  logic [7:0] rdata12;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m16 [16];
  logic [7:0] m12 [12];

  instr_mem #(.INSTR_WIDTH(8), .PC_WIDTH(4), .DEPTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata16),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  instr_mem #(.INSTR_WIDTH(8), .PC_WIDTH(4), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata12),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp16(input logic [3:0] a);
    return m16[a];
  endfunction

  function automatic logic [7:0] exp12(input logic [3:0] a);
    return (a < 4'd12) ? m12[a] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m16[i] = 8'h00;
    for (int i = 0; i < 12; i++) m12[i] = 8'h00;
  endtask

  task automatic chk_both(input string tag);
    chk({tag, "_d16"}, rdata16, exp16(raddr));
    chk({tag, "_d12"}, rdata12, exp12(raddr));
  endtask

  // One clock cycle, entered away from the rising edge: checks rdata before
  // the edge (old contents), applies the write to the model, checks after.
  task automatic cyc(input string tag, input logic w, input logic [3:0] wa,
                     input logic [7:0] wd, input logic [3:0] ra);
    we = w; waddr = wa; wdata = wd; raddr = ra;
    #1;
    chk_both({tag, "_pre"});
    @(posedge clk);
    if (rst_n && w) begin
      m16[wa] = wd;
      if (wa < 4'd12) m12[wa] = wd;
    end
    #1;
    chk_both({tag, "_post"});
    we = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [3:0] ra);
    raddr = ra;
    #1;
    chk_both(tag);
  endtask

  task automatic rd_all(input string tag);
    for (int a = 0; a < 16; a++) rd(tag, 4'(a));
  endtask

  initial begin
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] ra;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = 4'd3;
    model_clear();
    #2;
    chk_both("reset_state");
    rd_all("reset_all");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clears memory immediately, between edges
    cyc("wr3", 1'b1, 4'd3, 8'hA5, 4'd3);
    chk("wr3_val", rdata16, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_imm", rdata16, 8'h00);
    chk_both("rst_imm");
    #1;
    rst_n = 1'b1;
    #1;
    chk_both("rst_rel");
    @(negedge clk);

    // Interleaved write / read sweep
    wa = 4'd0; wd = 8'd1; ra = 4'd0;
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 1) begin
        cyc("sweep", 1'b1, wa, wd, ra);
        wa = wa + 4'd1; wd = wd + 8'd1;
      end else begin
        cyc("sweep", 1'b0, wa, wd, ra);
      end
      ra = ra + 4'd1;
    end
    for (int a = 0; a < 16; a++) begin
      rd("sweep2", 4'(a));
      chk("sweep2_k", rdata16, 8'(a + 1));
    end
    @(negedge clk);

    // Same-cycle read/write on one address: no pre-edge bypass
    cyc("prep5", 1'b1, 4'd5, 8'h11, 4'd5);
    we = 1'b1; waddr = 4'd5; wdata = 8'h22; raddr = 4'd5;
    #1;
    chk("rw5_pre", rdata16, 8'h11);
    @(posedge clk);
    m16[5] = 8'h22; m12[5] = 8'h22;
    #1;
    chk("rw5_post", rdata16, 8'h22);
    we = 1'b0;
    @(negedge clk);

    // we=0 is inert
    for (int c = 0; c < 10; c++)
      cyc("we0", 1'b0, 4'($urandom_range(0, 15)), 8'($urandom), 4'($urandom_range(0, 15)));
    rd_all("we0_all");
    @(negedge clk);

    // Out-of-range on the DEPTH=12 instance
    cyc("oor_w", 1'b1, 4'd13, 8'h5C, 4'd13);
    chk("oor_r13", rdata12, 8'h00);
    chk("oor_r13_d16", rdata16, 8'h5C);
    rd("oor_r1", 4'd1);
    chk("oor_nowrap", rdata12, 8'h02);
    rd_all("oor_all");
    @(negedge clk);

    // Reset during a write cycle: write lost, next write works
    we = 1'b1; waddr = 4'd2; wdata = 8'h77; raddr = 4'd2;
    #1;
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("rstw_lost", rdata16, 8'h00);
    we = 1'b0;
    rd_all("rstw_all");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rstw_next", 1'b1, 4'd2, 8'h77, 4'd2);
    chk("rstw_next_v", rdata16, 8'h77);

    // Random traffic with occasional reset pulses
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_both("rnd_rst");
        rst_n = 1'b1;
        @(negedge clk);
      end
      cyc("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          8'($urandom), 4'($urandom_range(0, 15)));
    end
    rd_all("final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instr_mem.md
Name: instr_mem

Overview:
- Per-core instruction memory: a small word-addressed RAM holding the program executed by a processor core.
- Read port is combinational and addressed by the core's program counter.
- Write port is synchronous and driven by the programming/loader logic.
- Asynchronous active-low reset clears the whole array, so an unprogrammed core fetches all-zero instructions.

Parameters:
- INSTR_WIDTH, default 8: width of one instruction word in bits.
- PC_WIDTH, default 4: width of the read and write addresses in bits.
- DEPTH, default 16: number of instruction words stored. Must satisfy 1 <= DEPTH <= 2**PC_WIDTH.

Ports:
- clk, input, 1: clock; all writes occur on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- raddr, input, PC_WIDTH: read address (program counter).
- rdata, output, INSTR_WIDTH: instruction word at raddr.
- we, input, 1: write enable, active-high, sampled on rising clk.
- waddr, input, PC_WIDTH: write address.
- wdata, input, INSTR_WIDTH: write data.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Storage: DEPTH words of INSTR_WIDTH bits each. No other state.
- Reset:
  - rst_n low immediately clears every word to 0, without waiting for a clock edge.
  - While rst_n is low, rdata = 0 for every raddr and writes are ignored.
  - Reset asserted mid-operation discards all prior contents.
- Write:
  - On a rising clk with rst_n high and we = 1, mem[waddr] <= wdata.
  - we = 0 leaves memory unchanged.
  - Latency: written value visible on rdata immediately after that same edge (zero-cycle read-after-write visibility post-edge).
- Read:
  - rdata = mem[raddr], purely combinational from raddr and array contents, with no clock latency.
  - rdata changes in the same delta/cycle as raddr.
- Same-address read/write in the same cycle: before the edge rdata shows the old word; after the edge it shows wdata. No bypass from wdata to rdata before the edge.
- Out-of-range addresses (value >= DEPTH, possible when DEPTH < 2**PC_WIDTH):
  - A write is ignored; no aliasing or wrap.
  - A read returns 0.
- No handshake. A write is accepted every cycle we is high; back-to-back writes to any addresses are allowed.
- X-free: rdata is never X after reset for any in-range or out-of-range raddr.

Test Plan (INSTR_WIDTH=8, PC_WIDTH=4, DEPTH=16 unless noted):
1. Reset clears memory:
   - Write mem[3]=8'hA5, then pulse rst_n low between clock edges.
   - rdata goes to 0 immediately with raddr=3 and stays 0 after release.
2. Interleaved write/sweep:
   - After reset, toggle we every cycle (0,1,0,1,...), advance waddr/wdata by 1 after each accepted write (start waddr=0, wdata=1), and increment raddr every cycle.
   - Each address k shows 0 until written, then k+1.
   - Second sweep after raddr wraps 15->0 shows 1,2,3,... at addresses 0,1,2,...
3. Same-cycle read/write:
   - raddr=waddr=5, mem[5]=8'h11, we=1, wdata=8'h22.
   - rdata=8'h11 before the edge, 8'h22 after it.
4. we=0 is inert:
   - Hold we=0 with varying waddr/wdata for 10 cycles.
   - All 16 words read back unchanged.
5. Out-of-range addresses (DEPTH=12, PC_WIDTH=4):
   - Write to waddr=13.
   - raddr=13 reads 0 and words 0..11 are unchanged, including word 1 (no wrap).
6. Reset mid-program:
   - Assert rst_n low during a write cycle.
   - The write is lost and all words read 0.
   - The next write after release takes effect normally.
